// File: rtl/onehot_req_arbiter.sv
// Round-robin request arbiter feeding the 8-to-3 encoder: latches request edges,
// grants one source at a time on d/enable and holds it until ack or timeout.
module onehot_req_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       ack,
  output logic [7:0] d,
  output logic       enable,
  output logic [7:0] pending,
  output logic       timeout,
  output logic       lost
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam bit         TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  logic [0:0] state;
  logic [7:0] req_q;
  logic [2:0] ptr;
  logic [2:0] gidx;
  logic [7:0] cnt;

  logic [7:0] req_edge;
  logic [7:0] clr_mask;
  logic [7:0] pending_nxt;
  logic       lost_set;
  logic       ack_done;
  logic       expire;
  logic       sel_found;
  logic [2:0] sel_idx;
  logic [2:0] cand;

  // Handshake: d/enable is a held grant. It stays constant while in GRANT and is
  // retired only by ack sampled high in GRANT (or by timeout); enable then drops
  // for at least one cycle before the next grant is issued.
  assign req_edge = req & ~req_q;
  assign ack_done = (state == GRANT) && ack;
  assign expire   = (state == GRANT) && !ack && TO_EN && (cnt == TO_LAST);
  assign clr_mask = ack_done ? (8'b1 << gidx) : 8'b0;

  // A new edge on the bit being acked wins over the clear and is not a loss.
  assign pending_nxt = (pending & ~clr_mask) | req_edge;
  assign lost_set    = |(req_edge & pending & ~clr_mask);

  // Search upward from ptr+1, wrapping, on the registered pending vector.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    cand      = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = ptr + 3'(k);
      if (!sel_found && pending[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_q   <= 8'd0;
      ptr     <= 3'd7;
      gidx    <= 3'd0;
      cnt     <= 8'd0;
      d       <= 8'd0;
      enable  <= 1'b0;
      pending <= 8'd0;
      timeout <= 1'b0;
      lost    <= 1'b0;
    end else begin
      req_q   <= req;
      pending <= pending_nxt;
      timeout <= expire;
      if (lost_set) lost <= 1'b1;
      case (state)
        IDLE: begin
          if (sel_found) begin
            d      <= 8'b1 << sel_idx;
            enable <= 1'b1;
            gidx   <= sel_idx;
            cnt    <= 8'd0;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (ack_done || expire) begin
            ptr    <= gidx;
            d      <= 8'd0;
            enable <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/onehot_req_arbiter.md
ONEHOT_REQ_ARBITER -- requirements
Module: onehot_req_arbiter

Upstream stage feeding the 8-to-3 encoder: latches request edges, grants one request at a time round-robin, drives the encoder's d and enable inputs, and holds each grant until the consumer acknowledges it.

Interface
REQ-001 Parameter TIMEOUT, default 15, is the maximum number of GRANT cycles without ack, legal range 0..255; 0 disables the timeout.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  8  level request lines, one per source; a request is a 0->1 transition.
REQ-005 ack  input  1  consumer accepts the current grant; sampled only in GRANT.
REQ-006 d  output  8  registered one-hot grant vector; connects to encoder d.
REQ-007 enable  output  1  registered grant-valid; connects to encoder enable.
REQ-008 pending  output  8  registered vector of latched, unserviced requests.
REQ-009 timeout  output  1  one-cycle pulse when a grant expires without ack.
REQ-010 lost  output  1  sticky flag: a request edge arrived on an already-pending bit.

Function
REQ-011 The block shall register req into req_q every cycle; edge = req & ~req_q.
REQ-012 An edge sampled at clock edge k shall set the corresponding pending bit, visible after edge k.
REQ-013 An edge on a bit already pending shall leave pending unchanged and set lost, which remains 1 until reset.
REQ-014 FSM states shall be exactly IDLE and GRANT.
REQ-015 In IDLE, d shall be 0 and enable shall be 0.
REQ-016 In IDLE with pending != 0, the block shall select the first pending bit searching upward from ptr+1, wrapping 7->0; it shall load d with that one-hot value, set enable=1, clear the timeout counter, and enter GRANT on the next edge.
REQ-017 Pending changes in IDLE shall take effect at the following edge (combinational search on registered pending); a grant issues one edge after the pending bit is set.
REQ-018 In GRANT, d and enable shall remain stable regardless of req or pending changes.
REQ-019 In GRANT with ack=1, the block shall clear the granted pending bit, set ptr to the granted index, drive d=0 and enable=0, and return to IDLE. Consecutive grants are therefore separated by at least one IDLE cycle.
REQ-020 If ack coincides with a new edge on the granted bit, the set shall win: the pending bit stays 1, lost is not set, and the bit is re-eligible.
REQ-021 Timeout counter: 8 bits, incremented each GRANT cycle without ack.
REQ-022 When TIMEOUT != 0, the counter equals TIMEOUT-1, and ack=0, the block shall pulse timeout for one cycle, keep the pending bit set, advance ptr to the granted index, clear d and enable, and return to IDLE.
REQ-023 An ack arriving on the timeout cycle shall take priority: normal completion, no timeout pulse.
REQ-024 d shall always be either 0 or one-hot; enable=1 if and only if d != 0.

Reset
REQ-025 While rst_n=0, all outputs shall be 0: d=0, enable=0, pending=0, timeout=0, lost=0.
REQ-026 While rst_n=0, internal state shall reset as: req_q=0, state=IDLE, ptr=7, counter=0.
REQ-027 Reset asserted mid-GRANT shall drop the grant immediately and discard all pending requests.
REQ-028 Because req_q resets to 0, a req bit held high at reset release shall count as an edge at the first sampling edge.

Verification
REQ-029 Single request: req=8'h04 for one cycle -> pending=8'h04 after the next edge, then d=8'h04 and enable=1 one edge later; ack=1 -> d=0, enable=0, pending=0.
REQ-030 Round-robin: req=8'h81 simultaneously after reset (ptr=7) -> grant 8'h01, then 8'h80 after ack; a second 8'h81 burst -> grant 8'h01, then 8'h80.
REQ-031 Timeout: grant with ack held 0 and TIMEOUT=15 -> timeout pulses after 15 GRANT cycles, pending bit retained, and the next grant moves to the next pending index.
REQ-032 Collision: edge on bit 3 while bit 3 is pending (not granted) -> lost=1 and pending unchanged; ack coinciding with a new edge on the granted bit -> pending bit remains 1 and lost=0.
REQ-033 Reset mid-GRANT: rst_n low while d=8'h10 -> all outputs 0 asynchronously; after release with req held at 8'h10 -> new grant 8'h10.
REQ-034 Protocol: every cycle the bench shall check that d is 0 or one-hot, that enable equals (d != 0), and that d is stable throughout GRANT.
